// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 instruction decode stage.
// Waits out the instruction-memory read latency after fetch issues an address,
// latches the instruction word into IR, reads the source register, then fires
// a one-cycle start pulse to either fetch (control flow) or execute.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : opcode 1101 raises sticky illegal_out and parks the FSM in HALT
//   undefined : opcode 1101 is a NOP that re-triggers fetch; no illegal_out port
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   decode_start        fetch has driven a new read address (1-cycle pulse)
//   pc_in               PC of the instruction, captured with decode_start
//   dout_in             instruction-memory read data
//   reg_data_in         register-file read data
//   sr_addr_out         register-file read address
//   opCode_out .. imm_flag_out   IR field decodes
//   reg_out             latched register value (JMP/JSRR base)
//   ir_pc_out           captured PC
//   fetch_start_out     1-cycle pulse to fetch
//   exec_start_out      1-cycle pulse to execute
//   busy_out            high while not IDLE
//   illegal_out         sticky reserved-opcode flag (macro builds only)
//
// State | meaning
// IDLE  | waiting for decode_start
// WAIT  | counting down memory read latency
// REGRD | IR valid, register file being read
// ISSUE | start pulse cycle
// HALT  | reserved opcode seen, only reset exits (macro builds only)
`timescale 1ns/1ps
module lc3_decode #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_start,
  input  logic [15:0] pc_in,
  input  logic [15:0] dout_in,
  input  logic [15:0] reg_data_in,
  output logic [2:0]  sr_addr_out,
  output logic [3:0]  opCode_out,
  output logic [8:0]  offset_out,
  output logic [15:0] reg_out,
  output logic [2:0]  br_nzp_out,
  output logic [2:0]  dr_out,
  output logic [4:0]  imm5_out,
  output logic        imm_flag_out,
  output logic [15:0] ir_pc_out,
  output logic        fetch_start_out,
  output logic        exec_start_out,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic        busy_out,
  output logic        illegal_out
`else
  output logic        busy_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REGRD = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] reg_q, reg_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        fetch_q, fetch_d;
  logic        exec_q, exec_d;
  logic        busy_q, busy_d;
  logic        ctrl_flow;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  // BR, JMP/RET, JSR/JSRR and RTI hand control straight back to fetch.
  always_comb begin
    ctrl_flow = (ir_q[15:12] == 4'b0000) || (ir_q[15:12] == 4'b1100) ||
                (ir_q[15:12] == 4'b0100) || (ir_q[15:12] == 4'b1000);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    reg_d   = reg_q;
    ir_pc_d = ir_pc_q;
    fetch_d = 1'b0;
    exec_d  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (decode_start) begin
          state_d = S_WAIT;
          ir_pc_d = pc_in;
          cnt_d   = LAT_M1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          ir_d    = dout_in;
          state_d = S_REGRD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_REGRD: begin
        reg_d   = reg_data_in;
        state_d = S_ISSUE;
        // Pulse is registered here so it is high exactly during ISSUE.
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (ir_q[15:12] == 4'b1101) illegal_d = 1'b1;
        else if (ctrl_flow)         fetch_d   = 1'b1;
        else                        exec_d    = 1'b1;
`else
        if (ctrl_flow || (ir_q[15:12] == 4'b1101)) fetch_d = 1'b1;
        else                                       exec_d  = 1'b1;
`endif
      end
      S_ISSUE: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        state_d = illegal_q ? S_HALT : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      ir_q      <= 16'h0000;
      reg_q     <= 16'h0000;
      ir_pc_q   <= 16'h0000;
      fetch_q   <= 1'b0;
      exec_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      reg_q     <= reg_d;
      ir_pc_q   <= ir_pc_d;
      fetch_q   <= fetch_d;
      exec_q    <= exec_d;
      busy_q    <= busy_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Field decodes come straight off the IR flop, so they hold until the next IR load.
  assign opCode_out   = ir_q[15:12];
  assign dr_out       = ir_q[11:9];
  assign offset_out   = ir_q[8:0];
  assign imm5_out     = ir_q[4:0];
  assign imm_flag_out = ir_q[5];
  assign br_nzp_out   = (ir_q[15:12] == 4'b0000) ? ir_q[11:9] : 3'b000;
  // ST and STI read the store data register from IR[11:9]; all others use IR[8:6].
  assign sr_addr_out  = ((ir_q[15:12] == 4'b0011) || (ir_q[15:12] == 4'b1011)) ?
                        ir_q[11:9] : ir_q[8:6];

  assign reg_out         = reg_q;
  assign ir_pc_out       = ir_pc_q;
  assign fetch_start_out = fetch_q;
  assign exec_start_out  = exec_q;
  assign busy_out        = busy_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_out     = illegal_q;
`endif

endmodule

// File: doc/lc3_decode.md
# lc3_decode

Instruction decode stage of the LC-3 core, sitting on the far side of the fetch unit's memory interface. After fetch presents an address, this block waits out the instruction-memory read latency and latches the returned word. It reads the source register and hands fetch the fields it consumes: opcode, PC offset, base-register value and branch condition. It then triggers either the next fetch or the execute stage.

## Interface
- MEM_LATENCY, 2, cycles from `decode_start` sample to valid `dout_in`; legal range 1..7.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- decode_start  in  1  one-cycle pulse: fetch has driven a new read address.
- pc_in  in  16  PC of the instruction being fetched, captured with `decode_start`.
- dout_in  in  16  instruction-memory read data.
- reg_data_in  in  16  register-file read data; valid one cycle after `sr_addr_out` is stable.
- sr_addr_out  out  3  register-file read address: IR[8:6] for JMP/JSRR/NOT/ADD/AND/LDR/STR, IR[11:9] for ST/STI.
- opCode_out  out  4  IR[15:12].
- offset_out  out  9  IR[8:0].
- reg_out  out  16  latched `reg_data_in` (JMP/JSRR base).
- br_nzp_out  out  3  IR[11:9] when opcode is 0000, else 000.
- dr_out  out  3  IR[11:9].
- imm5_out  out  5  IR[4:0].
- imm_flag_out  out  1  IR[5].
- ir_pc_out  out  16  captured `pc_in`.
- fetch_start_out  out  1  one-cycle pulse to fetch.
- exec_start_out  out  1  one-cycle pulse to execute.
- busy_out  out  1  high while not IDLE.
- illegal_out  out  1  reserved opcode flag; exists only with the macro.

## Operation
- States: IDLE, WAIT, REGRD, ISSUE, plus HALT when the macro is defined.
- **IDLE:**
  - `decode_start` = 1 moves to WAIT.
  - Captures `pc_in` into `ir_pc_out`.
  - Loads the wait counter with MEM_LATENCY-1.
- **WAIT:**
  - Counter decrements each edge.
  - On the edge where the counter is 0: IR <= `dout_in`, go to REGRD.
- **REGRD:** `sr_addr_out` is driven from IR. On the next edge: `reg_out` <= `reg_data_in`, go to ISSUE.
- **ISSUE:**
  - For control-flow opcodes 0000 (BR), 1100 (JMP/RET) and 0100 (JSR/JSRR): `fetch_start_out` = 1.
  - For all other legal opcodes: `exec_start_out` = 1. Execute re-triggers fetch.
  - Opcode 1000 (RTI) is treated as control-flow.
  - Return to IDLE on the next edge.
- All decoded field outputs are registered from IR and hold stable from REGRD until the next IR load.
- `decode_start` while `busy_out` = 1 is ignored and dropped; no queueing.
- Reset (`rst_n` = 0 at any edge, including mid-WAIT/REGRD) forces:
  - state IDLE, counter 0, IR 0x0000;
  - all outputs 0 (`sr_addr_out` 000, `opCode_out` 0000, `reg_out` 0x0000, `busy_out` 0, `illegal_out` 0).
- Reset wins over a simultaneous `decode_start`.

## Timing
- `decode_start` sampled at edge E0.
- IR loads at edge E0+MEM_LATENCY.
- `reg_out` loads at edge E0+MEM_LATENCY+1.
- Start pulse is high for exactly the cycle after E0+MEM_LATENCY+1. With default MEM_LATENCY=2: the cycle after E3.
- `busy_out`: 1 from after E0 through the ISSUE cycle.
- The earliest accepted next `decode_start` is at edge E0+MEM_LATENCY+3.
- Throughput: one instruction per MEM_LATENCY+3 cycles.
- Start pulses never overlap. Exactly one of `fetch_start_out` / `exec_start_out` fires per accepted instruction, except in the illegal case below.

## Configuration
- Macro: `DECODE_ILLEGAL_TRAP_EN`.
- **Defined:**
  - Opcode 1101 in ISSUE asserts `illegal_out` (sticky), fires no start pulse, and enters HALT.
  - HALT ignores `decode_start` and keeps `busy_out` = 1.
  - Only `rst_n` = 0 exits HALT.
- **Undefined:**
  - `illegal_out` port is absent.
  - Opcode 1101 is a NOP: `fetch_start_out` pulses, `exec_start_out` stays 0, return to IDLE.

## Test plan
- **Reset:** hold `rst_n` = 0 for 5 cycles mid-WAIT -> all outputs 0, `busy_out` 0, next `decode_start` accepted normally.
- **NOT:** `dout_in` = 0x9A3F, `reg_data_in` = 0x1234 -> `opCode_out` 1001, `dr_out` 5, `sr_addr_out` 0, `offset_out` 0x03F, `br_nzp_out` 000, `exec_start_out` pulse after E3, `fetch_start_out` 0.
- **BR:** `dout_in` = 0x0A05 -> `opCode_out` 0000, `br_nzp_out` 101, `offset_out` 0x005, `fetch_start_out` single pulse after E3.
- **JMP R3:** `dout_in` = 0xC0C0, `reg_data_in` = 0x3000 -> `sr_addr_out` 3, `reg_out` 0x3000, `fetch_start_out` pulse.
- **ADD immediate with overrun:** `dout_in` = 0x1262, second `decode_start` at E1 -> `imm_flag_out` 1, `imm5_out` 00010, `dr_out` 1; the second start is dropped (one `exec_start_out` only).
- **Illegal opcode:** `dout_in` = 0xD000 -> with the macro: `illegal_out` 1, no pulses, `busy_out` stuck 1 until reset. Without the macro: `fetch_start_out` pulse, back to IDLE.
